// File: rtl/data_mem.sv
// Word-organised data memory for the single-cycle core: combinational reads,
// clocked writes, zero-fill sequencer after reset, sticky access-error flags.
module data_mem #(
    parameter int unsigned DATA_WIDTH_P      = 32,
    parameter int unsigned DATA_ADDR_WIDTH_P = 32,
    parameter int unsigned DEPTH_LOG2_P      = 6,
    parameter int unsigned CNT_WIDTH_P       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_ADDR_WIDTH_P-1:0] i_addr,
    input  logic                         i_wr_en,
    input  logic [DATA_WIDTH_P-1:0]      i_wr_data,
    output logic [DATA_WIDTH_P-1:0]      o_rd_data,
    output logic                         o_ready,
    output logic                         o_align_err,
    output logic                         o_range_err,
    output logic [CNT_WIDTH_P-1:0]       o_wr_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2_P;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [DEPTH_LOG2_P-1:0] ptr;
    logic [DEPTH_LOG2_P-1:0] ptr_next;

    logic [DATA_WIDTH_P-1:0] mem [DEPTH];

    logic [DEPTH_LOG2_P-1:0] index;
    logic                    in_range;
    logic                    aligned;
    logic                    wr_req;
    logic                    wr_commit;

    logic                    mem_we;
    logic [DEPTH_LOG2_P-1:0] mem_addr;
    logic [DATA_WIDTH_P-1:0] mem_wdata;

    assign index     = i_addr[DEPTH_LOG2_P+1:2];
    assign in_range  = (i_addr[DATA_ADDR_WIDTH_P-1:DEPTH_LOG2_P+2] == '0);
    assign aligned   = (i_addr[1:0] == 2'b00);
    assign wr_req    = (state == READY) && i_wr_en;
    assign wr_commit = wr_req && in_range && aligned;

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        mem_we     = 1'b0;
        mem_addr   = index;
        mem_wdata  = i_wr_data;
        case (state)
            CLEAR: begin
                // Core store strobes are ignored here; the port belongs to the sequencer.
                mem_we    = 1'b1;
                mem_addr  = ptr;
                mem_wdata = '0;
                ptr_next  = ptr + 1'b1;
                if (ptr == '1) begin
                    state_next = READY;
                end
            end
            READY: begin
                mem_we = wr_commit;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= CLEAR;
            ptr         <= '0;
            o_wr_count  <= '0;
            o_align_err <= 1'b0;
            o_range_err <= 1'b0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            if (wr_commit) begin
                o_wr_count <= o_wr_count + 1'b1;
            end
            if (wr_req && !aligned) begin
                o_align_err <= 1'b1;
            end
            if (wr_req && !in_range) begin
                o_range_err <= 1'b1;
            end
        end
    end

    // Array has no reset; an edge under reset is in CLEAR and only zeroes mem[0].
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    assign o_ready   = (state == READY);
    assign o_rd_data = (o_ready && in_range) ? mem[index] : '0;

endmodule
